// File: rtl/conv_layer_sched.sv
// conv_layer_sched: address/strobe sequencer for conv (L0), 2x2 max-pool (L1) and flatten (L2).
module conv_layer_sched #(
  parameter int IMG_W = 64,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  output logic [AW-1:0] iaddr,
  output logic          tap_vld,
  output logic          tap_pad,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [2:0]    csel,
  output logic          smp_vld,
  output logic          smp_first,
  output logic          smp_pad,
  output logic [1:0]    phase
);
  localparam int LW = $clog2(IMG_W);
  localparam int PW = LW - 1;
  typedef enum logic [3:0] {
    IDLE, C_TAP, C_WAIT, C_WR0, C_WR1, P_RD, P_WAIT, P_WR1, P_WR2, DONE
  } state_t;
  state_t state, nxt;
  logic [3:0] tap;
  logic [AW-1:0] pix;
  logic [1:0] q;
  logic [2*PW-1:0] j;
  logic k;
  logic [1:0] ty, tx;
  logic [LW:0] yy, xx;
  logic pad;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = ready ? C_TAP : IDLE;
      C_TAP:   nxt = (tap == 4'd8) ? C_WAIT : C_TAP;
      C_WAIT:  nxt = C_WR0;
      C_WR0:   nxt = C_WR1;
      C_WR1:   nxt = (&pix) ? P_RD : C_TAP;
      P_RD:    nxt = (&q) ? P_WAIT : P_RD;
      P_WAIT:  nxt = P_WR1;
      P_WR1:   nxt = P_WR2;
      P_WR2:   nxt = (&j && k) ? DONE : P_RD;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // counters return to zero on their own at the end of each phase
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tap <= '0;
      pix <= '0;
      q   <= '0;
      j   <= '0;
      k   <= 1'b0;
    end else begin
      tap <= (state == C_TAP && tap != 4'd8) ? tap + 4'd1 : 4'd0;
      pix <= (state == C_WR1) ? pix + 1'b1 : pix;
      q   <= (state == P_RD) ? q + 2'd1 : q;
      k   <= (state == P_WR2) ? ~k : k;
      j   <= (state == P_WR2 && k) ? j + 1'b1 : j;
    end
  // an out-of-range row/column shows up as the carry bit of yy/xx
  always_comb begin
    ty = (tap >= 4'd6) ? 2'd2 : (tap >= 4'd3) ? 2'd1 : 2'd0;
    tx = (tap == 4'd1 || tap == 4'd4 || tap == 4'd7) ? 2'd1 :
         (tap == 4'd2 || tap == 4'd5 || tap == 4'd8) ? 2'd2 : 2'd0;
    yy = {1'b0, pix[AW-1:LW]} + (LW+1)'(ty) - (LW+1)'(1);
    xx = {1'b0, pix[LW-1:0]} + (LW+1)'(tx) - (LW+1)'(1);
    pad = yy[LW] | xx[LW];
    busy = state != IDLE;
    phase = (state == IDLE) ? 2'd0 : (state == DONE) ? 2'd3 : (state >= P_RD) ? 2'd2 : 2'd1;
    tap_vld = state == C_TAP;
    tap_pad = tap_vld & pad;
    iaddr = (tap_vld && !pad) ? {yy[LW-1:0], xx[LW-1:0]} : '0;
    crd = state == P_RD;
    caddr_rd = crd ? {j[2*PW-1:PW], q[1], j[PW-1:0], q[0]} : '0;
    cwr = state == C_WR0 || state == C_WR1 || state == P_WR1 || state == P_WR2;
    caddr_wr = (state == C_WR0 || state == C_WR1) ? pix :
               (state == P_WR1) ? {{(AW-2*PW){1'b0}}, j} :
               (state == P_WR2) ? {{(AW-2*PW-1){1'b0}}, j, k} : '0;
    csel = (state == C_WR0) ? 3'd1 : (state == C_WR1) ? 3'd2 :
           (state == P_RD) ? (k ? 3'd2 : 3'd1) :
           (state == P_WR1) ? (k ? 3'd4 : 3'd3) :
           (state == P_WR2) ? 3'd5 : 3'd0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      smp_vld   <= 1'b0;
      smp_first <= 1'b0;
      smp_pad   <= 1'b0;
    end else begin
      smp_vld   <= tap_vld | crd;
      smp_first <= (tap_vld && tap == 4'd0) || (crd && q == 2'd0);
      smp_pad   <= tap_pad;
    end
endmodule

// File: tb/tb_conv_layer_sched.sv
// tb_conv_layer_sched: directed address-trace and run-length checks for conv_layer_sched.
module tb_conv_layer_sched;
  logic clk = 0, reset = 0, ready = 0;
  logic busy, tap_vld, tap_pad, crd, cwr, smp_vld, smp_first, smp_pad;
  logic [11:0] iaddr, caddr_rd, caddr_wr;
  logic [2:0] csel;
  logic [1:0] phase;
  logic [48:0] all_out;
  int nvec = 0, nerr = 0;
  int nbusy, nl0, nl1, nl2, nrd, novl;
  bit mon = 0;

  conv_layer_sched #(.IMG_W(64), .AW(12)) dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy), .iaddr(iaddr),
    .tap_vld(tap_vld), .tap_pad(tap_pad), .crd(crd), .caddr_rd(caddr_rd),
    .cwr(cwr), .caddr_wr(caddr_wr), .csel(csel), .smp_vld(smp_vld),
    .smp_first(smp_first), .smp_pad(smp_pad), .phase(phase)
  );

  always #5 clk = ~clk;
  assign all_out = {busy, iaddr, tap_vld, tap_pad, crd, caddr_rd, cwr, caddr_wr,
                    csel, smp_vld, smp_first, smp_pad, phase};

  always @(negedge clk)
    if (mon) begin
      if (busy) nbusy++;
      if (cwr && (csel == 3'd1 || csel == 3'd2)) nl0++;
      if (cwr && (csel == 3'd3 || csel == 3'd4)) nl1++;
      if (cwr && csel == 3'd5) nl2++;
      if (crd) nrd++;
      if ((crd && cwr) || (!crd && !cwr && csel != 3'd0)) novl++;
    end

  task step;
    @(posedge clk);
    #1;
  endtask

  task trace_pixel(input string nm, input logic [8:0] padm, input logic [8:0][11:0] ad,
                   input logic [11:0] p);
    logic [9:0] pm;
    logic [17:0] e;
    pm = {padm, 1'b0};
    for (int t = 0; t < 9; t++) begin
      e = {1'b1, padm[t], padm[t] ? 12'd0 : ad[t], 1'b0, 1'b0, 2'd1};
      nvec++;
      if ({busy, tap_pad, iaddr, cwr, crd, phase} !== e || tap_vld !== 1'b1) begin
        nerr++;
        $display("FAIL %s tap%0d: got vld=%b pad=%b iaddr=%0d busy=%b ph=%0d, want pad=%b iaddr=%0d",
                 nm, t, tap_vld, tap_pad, iaddr, busy, phase, padm[t], e[15:4]);
      end
      nvec++;
      if ({smp_vld, smp_first, smp_pad} !== ((t == 0) ? 3'b000 : {1'b1, t == 1, pm[t]})) begin
        nerr++;
        $display("FAIL %s smp%0d: got %b%b%b, want %b%b%b", nm, t, smp_vld, smp_first, smp_pad,
                 t != 0, t == 1, (t == 0) ? 1'b0 : pm[t]);
      end
      step;
    end
    nvec++;
    if ({tap_vld, cwr, crd, csel, smp_vld, smp_first, smp_pad} !== {6'b0, 1'b1, 1'b0, padm[8]}) begin
      nerr++;
      $display("FAIL %s wait: got tv=%b cwr=%b crd=%b csel=%0d smp=%b%b%b", nm, tap_vld, cwr, crd,
               csel, smp_vld, smp_first, smp_pad);
    end
    step;
    for (int w = 0; w < 2; w++) begin
      nvec++;
      if ({cwr, crd, csel, caddr_wr, busy} !== {1'b1, 1'b0, 3'(w + 1), p, 1'b1}) begin
        nerr++;
        $display("FAIL %s wr%0d: got cwr=%b crd=%b csel=%0d addr=%0d, want csel=%0d addr=%0d",
                 nm, w, cwr, crd, csel, caddr_wr, w + 1, p);
      end
      step;
    end
  endtask

  task trace_pool(input string nm, input logic k, input logic [3:0][11:0] ra, input logic [11:0] j);
    for (int q = 0; q < 4; q++) begin
      nvec++;
      if ({crd, cwr, csel, caddr_rd, tap_vld, phase} !== {1'b1, 1'b0, k ? 3'd2 : 3'd1, ra[q], 1'b0, 2'd2}) begin
        nerr++;
        $display("FAIL %s rd%0d: got crd=%b cwr=%b csel=%0d addr=%0d ph=%0d, want addr=%0d",
                 nm, q, crd, cwr, csel, caddr_rd, phase, ra[q]);
      end
      nvec++;
      if ({smp_vld, smp_first} !== ((q == 0) ? 2'b00 : {1'b1, q == 1})) begin
        nerr++;
        $display("FAIL %s smp%0d: got %b%b", nm, q, smp_vld, smp_first);
      end
      step;
    end
    nvec++;
    if ({crd, cwr, csel, smp_vld, smp_first} !== 7'b0000010) begin
      nerr++;
      $display("FAIL %s wait: got crd=%b cwr=%b csel=%0d smp=%b%b", nm, crd, cwr, csel, smp_vld, smp_first);
    end
    step;
    nvec++;
    if ({cwr, crd, csel, caddr_wr} !== {1'b1, 1'b0, k ? 3'd4 : 3'd3, j}) begin
      nerr++;
      $display("FAIL %s wr1: got cwr=%b csel=%0d addr=%0d, want csel=%0d addr=%0d", nm, cwr, csel,
               caddr_wr, k ? 4 : 3, j);
    end
    step;
    nvec++;
    if ({cwr, crd, csel, caddr_wr} !== {1'b1, 1'b0, 3'd5, 12'(2 * j + 12'(k))}) begin
      nerr++;
      $display("FAIL %s wr2: got cwr=%b csel=%0d addr=%0d, want csel=5 addr=%0d", nm, cwr, csel,
               caddr_wr, 2 * j + 12'(k));
    end
    step;
  endtask

  localparam logic [8:0] PAD0 = 9'b001001111;
  localparam logic [8:0][11:0] AD0 = {12'd65, 12'd64, 12'd0, 12'd1, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
  localparam logic [8:0] PADL = 9'b111100100;
  localparam logic [8:0][11:0] ADL = {12'd0, 12'd0, 12'd0, 12'd0, 12'd4095, 12'd4094, 12'd0, 12'd4031, 12'd4030};
  localparam logic [3:0][11:0] RA33 = {12'd195, 12'd194, 12'd131, 12'd130};

  task test_reset;
    #12;
    nvec++;
    if (all_out !== 49'd0) begin
      nerr++;
      $display("FAIL reset_hold: outputs %h, want 0", all_out);
    end
    #2 reset = 1;
    step;
    step;
    nvec++;
    if (all_out !== 49'd0) begin
      nerr++;
      $display("FAIL reset_idle: outputs %h, want 0", all_out);
    end
  endtask

  task test_pulse_pixel0;
    ready = 1;
    step;
    ready = 0;
    trace_pixel("pulse_px0", PAD0, AD0, 12'd0);
  endtask

  task test_reset_midrun;
    repeat (99 * 12 + 3) step;
    nvec++;
    if ({tap_vld, tap_pad, iaddr} !== {1'b1, 1'b0, 12'd99}) begin
      nerr++;
      $display("FAIL px100_tap3: got vld=%b pad=%b iaddr=%0d, want 1 0 99", tap_vld, tap_pad, iaddr);
    end
    #2 reset = 0;
    #1;
    nvec++;
    if (all_out !== 49'd0) begin
      nerr++;
      $display("FAIL async_reset: outputs %h, want 0", all_out);
    end
    step;
    step;
    nvec++;
    if (all_out !== 49'd0) begin
      nerr++;
      $display("FAIL reset_held: outputs %h, want 0", all_out);
    end
    #2 reset = 1;
    repeat (20) step;
    nvec++;
    if ({busy, phase, tap_vld, crd, cwr} !== 5'd0) begin
      nerr++;
      $display("FAIL no_resume: busy=%b phase=%0d tv=%b crd=%b cwr=%b, want 0", busy, phase, tap_vld, crd, cwr);
    end
  endtask

  task test_full_run;
    nbusy = 0; nl0 = 0; nl1 = 0; nl2 = 0; nrd = 0; novl = 0;
    mon = 1;
    ready = 1;
    step;
    trace_pixel("run_px0", PAD0, AD0, 12'd0);
    repeat (4094 * 12) step;
    trace_pixel("run_px4095", PADL, ADL, 12'd4095);
    repeat (66 * 7) step;
    trace_pool("pool33_k0", 1'b0, RA33, 12'd33);
    trace_pool("pool33_k1", 1'b1, RA33, 12'd33);
    for (int i = 0; i < 70000 && busy; i++) step;
    mon = 0;
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL run_timeout: busy=%b after bound, want 0", busy);
    end
    nvec++;
    if (nbusy !== 63489) begin
      nerr++;
      $display("FAIL busy_len: got %0d cycles, want 63489", nbusy);
    end
    nvec++;
    if ({nl0, nl1, nl2, nrd} !== {32'd8192, 32'd2048, 32'd2048, 32'd8192}) begin
      nerr++;
      $display("FAIL counts: L0=%0d L1=%0d L2=%0d rd=%0d, want 8192 2048 2048 8192", nl0, nl1, nl2, nrd);
    end
    nvec++;
    if (novl !== 0) begin
      nerr++;
      $display("FAIL strobe_excl: %0d bad cycles, want 0", novl);
    end
  endtask

  task test_second_run;
    nvec++;
    if ({busy, phase} !== 3'd0) begin
      nerr++;
      $display("FAIL idle_gap: busy=%b phase=%0d, want 0 0", busy, phase);
    end
    step;
    trace_pixel("run2_px0", PAD0, AD0, 12'd0);
    ready = 0;
    #2 reset = 0;
    #1;
  endtask

  initial begin
    test_reset;
    test_pulse_pixel0;
    test_reset_midrun;
    test_full_run;
    test_second_run;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
